alu_mul_sequencer: RTL and testbench



---
 rtl/alu_mul_sequencer_if.sv | 39 +++
 rtl/alu_mul_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the multiplier's start/result handshake and its ALU request bus.
// Handshake rules:
//   start_i/ready_o : a start is accepted on a rising edge where start_i=1 and
//                     ready_o=1; start_i while ready_o=0 is dropped, not queued.
//   alu_req_o/alu_gnt_i : one ALU operation completes on a rising edge where
//                     alu_req_o=1 and alu_gnt_i=1; while alu_req_o=1 and
//                     alu_gnt_i=0 the requester holds alu_a_o/alu_b_o/alu_shift_o
//                     stable; alu_gnt_i with alu_req_o=0 has no effect.
interface alu_mul_sequencer_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] product_o;
  logic            alu_req_o;
  logic            alu_gnt_i;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [3:0]      alu_op_o;
  logic            alu_shift_o;
  logic [XLEN-1:0] alu_result_i;

  // The sequencer: consumes start/operands, masters the shared ALU.
  modport master (
    input  start_i, op_a_i, op_b_i, alu_gnt_i, alu_result_i,
    output ready_o, done_o, product_o, alu_req_o, alu_a_o, alu_b_o,
           alu_op_o, alu_shift_o
  );

  // The environment: issues starts, arbitrates and executes ALU operations.
  modport slave (
    output start_i, op_a_i, op_b_i, alu_gnt_i, alu_result_i,
    input  ready_o, done_o, product_o, alu_req_o, alu_a_o, alu_b_o,
           alu_op_o, alu_shift_o
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared execute-stage ALU for every
// accumulate (ADD) and multiplicand doubling (ADD-with-shift). Returns the low
// XLEN bits of the product (valid for signed and unsigned RISC-V MUL).
// Optional feature macro: MUL_EARLY_EXIT_EN -- stop iterating as soon as the
// remaining multiplier bits are all zero; without it every multiply takes
// exactly XLEN iterations.
module alu_mul_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_mul_sequencer_if.master bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_m;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  r_product;
  logic [CNT_W-1:0] r_count;

  logic             w_q_zero;
  logic             w_q_next_zero;
  logic             w_last_iter;
  logic             w_alu_req;
  logic             w_alu_shift;
  logic [XLEN-1:0]  w_alu_a;
  logic [XLEN-1:0]  w_alu_b;

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier bits exhausted: no further partial products.
  assign w_q_zero      = (r_q == '0);
  assign w_q_next_zero = (r_q[XLEN-1:1] == '0);
`else
  assign w_q_zero      = 1'b0;
  assign w_q_next_zero = 1'b0;
`endif

  // The shift being granted now completes the final iteration.
  assign w_last_iter = (r_count == CNT_W'(XLEN - 1));

  // Next-state decode and ALU request/operand selection.
  always_comb begin
    w_state_nxt = r_state;
    w_alu_req   = 1'b0;
    w_alu_a     = '0;
    w_alu_b     = '0;
    w_alu_shift = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_q_zero)    w_state_nxt = S_DONE;
        else if (r_q[0]) w_state_nxt = S_ADD;
        else             w_state_nxt = S_SHIFT;
      end
      S_ADD: begin
        w_alu_req = 1'b1;
        w_alu_a   = r_acc;
        w_alu_b   = r_m;
        if (bus.alu_gnt_i) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_alu_req   = 1'b1;
        w_alu_a     = r_m;
        w_alu_b     = XLEN'(1);
        w_alu_shift = 1'b1;
        if (bus.alu_gnt_i) begin
          if (w_last_iter || w_q_next_zero) w_state_nxt = S_DONE;
          else                              w_state_nxt = S_CHECK;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus datapath updates on accepted start and granted ALU ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_m     <= bus.op_a_i;
            r_q     <= bus.op_b_i;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        S_ADD: begin
          if (bus.alu_gnt_i) r_acc <= bus.alu_result_i;
        end
        S_SHIFT: begin
          if (bus.alu_gnt_i) begin
            r_m     <= bus.alu_result_i;
            r_q     <= r_q >> 1;
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
      // Result becomes visible in the same cycle done_o is raised.
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_product <= r_acc;
    end
  end

  assign bus.ready_o     = (r_state == S_IDLE);
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.product_o   = r_product;
  assign bus.alu_req_o   = w_alu_req;
  assign bus.alu_a_o     = w_alu_a;
  assign bus.alu_b_o     = w_alu_b;
  assign bus.alu_op_o    = 4'b0010;
  assign bus.alu_shift_o = w_alu_shift;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: directed vector table, hand-written reset and
// stall sequences, and randomized multiplies with random ALU grants.
module tb_alu_mul_sequencer;

  localparam int XLEN = 64;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.XLEN(XLEN)) bus ();

  alu_mul_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Shared ALU: ADD, or ADD-with-shift (a << b[4:0]).
  always_comb begin
    if (bus.alu_shift_o) bus.alu_result_i = bus.alu_a_o << bus.alu_b_o[4:0];
    else                 bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
  end

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_checks;
  logic [XLEN-1:0] exp_q[$];

  task automatic check64(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Iterations actually needed: up to and including the top set multiplier bit
  // when exiting early, otherwise always XLEN.
  function automatic int model_iters(input logic [XLEN-1:0] b);
    int h;
    h = -1;
    for (int i = 0; i < XLEN; i++) if (b[i]) h = i;
    return EE ? (h + 1) : XLEN;
  endfunction

  // Cycle of done_o counted from the accepting edge: one CHECK per iteration,
  // one SHIFT per iteration, one ADD per set bit, one DONE, plus stalls.
  function automatic int model_latency(input logic [XLEN-1:0] b, input int stalls);
    if (model_iters(b) == 0) return 2 + stalls;
    return 2 * model_iters(b) + $countones(b) + 1 + stalls;
  endfunction

  function automatic int model_reqs(input logic [XLEN-1:0] b, input int stalls);
    return model_iters(b) + $countones(b) + stalls;
  endfunction

  // ---------------- driver ----------------
  typedef struct {
    logic [XLEN-1:0] prod;
    int cyc;
    int stalls;
    int add_gnts;
    int reqs;
    int dones;
    int ready_bad;
    int unstable;
    int op_bad;
    bit timeout;
    bit tail_ok;
  } res_t;

  // gmode: 0 = grant always, 1 = random grant, 2 = withhold grant stall_n
  // cycles on the first ADD. pulse_cyc: cycle to pulse start_i while busy.
  // Entered and left at a negedge with the DUT idle.
  task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int gmode, input int stall_n, input int pulse_cyc,
                        output res_t r);
    int stall_left;
    bit done_seen;
    bit prev_stall;
    logic [XLEN-1:0] pa, pb;
    logic ps;
    r.prod = '0; r.cyc = 0; r.stalls = 0; r.add_gnts = 0; r.reqs = 0;
    r.dones = 0; r.ready_bad = 0; r.unstable = 0; r.op_bad = 0;
    r.timeout = 1'b0; r.tail_ok = 1'b0;
    stall_left = stall_n; done_seen = 1'b0; prev_stall = 1'b0;
    pa = '0; pb = '0; ps = 1'b0;
    bus.op_a_i = a; bus.op_b_i = b; bus.start_i = 1'b1; bus.alu_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    r.cyc = 1;
    while (!done_seen && !r.timeout) begin
      if (r.cyc == pulse_cyc) begin
        bus.start_i = 1'b1; bus.op_a_i = 64'd100; bus.op_b_i = 64'd100;
      end else begin
        bus.start_i = 1'b0;
      end
      if (prev_stall && (bus.alu_a_o !== pa || bus.alu_b_o !== pb ||
                         bus.alu_shift_o !== ps || bus.alu_req_o !== 1'b1))
        r.unstable++;
      if (bus.ready_o) r.ready_bad++;
      if (bus.alu_req_o && bus.alu_op_o !== 4'b0010) r.op_bad++;
      case (gmode)
        1: bus.alu_gnt_i = 1'($urandom_range(0, 1));
        2: begin
          if (bus.alu_req_o && !bus.alu_shift_o && stall_left > 0) begin
            bus.alu_gnt_i = 1'b0;
            stall_left--;
          end else begin
            bus.alu_gnt_i = 1'b1;
          end
        end
        default: bus.alu_gnt_i = 1'b1;
      endcase
      prev_stall = bus.alu_req_o && !bus.alu_gnt_i;
      pa = bus.alu_a_o; pb = bus.alu_b_o; ps = bus.alu_shift_o;
      if (bus.alu_req_o) begin
        r.reqs++;
        if (!bus.alu_gnt_i)        r.stalls++;
        else if (!bus.alu_shift_o) r.add_gnts++;
      end
      if (bus.done_o) begin
        done_seen = 1'b1;
        r.dones++;
        r.prod = bus.product_o;
      end else begin
        @(posedge clk);
        @(negedge clk);
        r.cyc++;
        if (r.cyc > 1000) r.timeout = 1'b1;
      end
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (bus.done_o) r.dones++;
    r.tail_ok = bus.ready_o && !bus.done_o;
  endtask

  // One multiply checked against the model.
  task automatic do_op(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int gmode, input int stall_n, input int pulse_cyc,
                       output res_t r);
    exp_q.push_back(a * b);
    run_op(a, b, gmode, stall_n, pulse_cyc, r);
    check_int({tag, " timeout"}, int'(r.timeout), 0);
    check64({tag, " product"}, r.prod, exp_q.pop_front());
    check_int({tag, " latency"}, r.cyc, model_latency(b, r.stalls));
    check_int({tag, " alu_requests"}, r.reqs, model_reqs(b, r.stalls));
    check_int({tag, " done_pulses"}, r.dones, 1);
    check_int({tag, " back_to_idle"}, int'(r.tail_ok), 1);
    check_int({tag, " ready_while_busy"}, r.ready_bad, 0);
    check_int({tag, " stall_stability"}, r.unstable, 0);
    check_int({tag, " alu_opcode"}, r.op_bad, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int gmode;
    int stall_n;
    int pulse_cyc;
    logic [XLEN-1:0] exp_prod;
    int exp_add;
    int exp_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    res_t r;
    logic [XLEN-1:0] ra, rb;
    int reached;
    n_pass = 0;
    n_checks = 0;

    tbl[0] = '{64'd3, 64'd5, 0, 0, 0, 64'd15, 2, EE ? 9 : 131};
    tbl[1] = '{64'h1234, 64'd0, 0, 0, 0, 64'd0, 0, EE ? 2 : 129};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, EE ? 6 : 130};
    tbl[3] = '{64'd1, 64'h8000_0000_0000_0000, 0, 0, 0, 64'h8000_0000_0000_0000, 1, 130};
    tbl[4] = '{64'd7, 64'd3, 2, 3, 0, 64'd21, 2, EE ? 10 : 134};
    tbl[5] = '{64'd2, 64'd9, 0, 0, 3, 64'd18, 2, EE ? 11 : 131};

    // Reset state, with a stray grant that must be ignored.
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.op_a_i = '0; bus.op_b_i = '0; bus.alu_gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    check_int("reset ready_o", int'(bus.ready_o), 1);
    check_int("reset done_o", int'(bus.done_o), 0);
    check64("reset product_o", bus.product_o, '0);
    check_int("reset alu_req_o", int'(bus.alu_req_o), 0);
    check64("reset alu_a_o", bus.alu_a_o, '0);
    check64("reset alu_b_o", bus.alu_b_o, '0);
    check_int("reset alu_shift_o", int'(bus.alu_shift_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_int("idle ignores gnt", int'(bus.alu_req_o), 0);
    check_int("idle ready_o", int'(bus.ready_o), 1);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].gmode,
            tbl[i].stall_n, tbl[i].pulse_cyc, r);
      check64($sformatf("vec%0d table_product", i), r.prod, tbl[i].exp_prod);
      check_int($sformatf("vec%0d table_cycle", i), r.cyc, tbl[i].exp_cyc);
      check_int($sformatf("vec%0d add_grants", i), r.add_gnts, tbl[i].exp_add);
      check_int($sformatf("vec%0d stalls", i), r.stalls, tbl[i].stall_n);
    end

    // Reset during an ADD: immediate return to idle, result cleared.
    bus.op_a_i = 64'd5; bus.op_b_i = 64'd3; bus.start_i = 1'b1; bus.alu_gnt_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    reached = 0;
    for (int i = 0; i < 10 && reached == 0; i++) begin
      if (bus.alu_req_o && !bus.alu_shift_o) reached = 1;
      else @(negedge clk);
    end
    check_int("rst_mid reached ADD", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("rst_mid ready_o", int'(bus.ready_o), 1);
    check64("rst_mid product_o", bus.product_o, '0);
    check_int("rst_mid alu_req_o", int'(bus.alu_req_o), 0);
    check_int("rst_mid done_o", int'(bus.done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.alu_gnt_i = 1'b1;
    reached = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_o || !bus.ready_o) reached++;
    end
    check_int("rst_mid stays idle", reached, 0);
    do_op("after_rst", 64'd4, 64'd4, 0, 0, 0, r);

    // Randomized multiplies with random grants.
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) rb = '0;
      do_op($sformatf("rand%0d", i), ra, rb, 1, 0, 0, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
